instr_stream_encoder: RTL and testbench

- Inverse of the instruction decoder: accepts one instruction per handshake as a 6-bit internal instruction code plus operand fields, packs it into a 32-bit MIPS machine word, and writes it to instruction memory.
- Writes go to consecutive word addresses starting at a base address.
- Used by self-check benches and the boot loader to build IM contents without an external assembler.
- Supported set is the CPU's set: addu, subu, jr, sll, ori, lw, sw, beq, lui, jal.

---
 rtl/instr_stream_encoder_pkg.sv | 51 +++++
 rtl/instr_field_packer.sv | 49 ++++
 rtl/instr_stream_encoder.sv | 170 +++++++++++++++++
 tb/tb_instr_stream_encoder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_stream_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instr_stream_encoder_pkg
// Description : Shared definitions for the instruction stream encoder.
//               - Internal instruction codes (addu .. jal).
//               - MIPS opcode and funct constants.
//               - Encoder FSM state type.
//               - Helper that identifies control-transfer codes.
// Revision    : 1.0 - initial release
// ============================================================================
package instr_stream_encoder_pkg;

    // Internal instruction codes shared with the decoder
    localparam logic [5:0] CODE_ADDU = 6'h01;
    localparam logic [5:0] CODE_SUBU = 6'h02;
    localparam logic [5:0] CODE_JR   = 6'h03;
    localparam logic [5:0] CODE_SLL  = 6'h04;
    localparam logic [5:0] CODE_ORI  = 6'h05;
    localparam logic [5:0] CODE_LW   = 6'h06;
    localparam logic [5:0] CODE_SW   = 6'h07;
    localparam logic [5:0] CODE_BEQ  = 6'h08;
    localparam logic [5:0] CODE_LUI  = 6'h09;
    localparam logic [5:0] CODE_JAL  = 6'h0A;

    // MIPS primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_JAL     = 6'b000011;

    // MIPS funct codes for SPECIAL instructions
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_SLL  = 6'b000000;

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_PAD    = 1'b1
    } enc_state_e;

    // Instructions whose architectural delay slot gets a NOP when padding
    function automatic logic is_delay_slot_code(input logic [5:0] code);
        return (code == CODE_BEQ) || (code == CODE_JR) || (code == CODE_JAL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_field_packer.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_packer
// Description : Combinational packer from internal instruction code plus
//               operand fields to a 32-bit MIPS machine word. Fields that
//               the selected format does not use are forced to zero.
// Ports       : i_code                internal instruction code
//               i_rs/i_rt/i_rd        register fields
//               i_shamt               shift amount
//               i_imm                 16-bit immediate
//               i_target              26-bit jump target
//               o_word                encoded machine word (0 if unsupported)
//               o_valid_code          1 when i_code is a supported instruction
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_packer
    import instr_stream_encoder_pkg::*;
(
    input  logic [5:0]  i_code,
    input  logic [4:0]  i_rs,
    input  logic [4:0]  i_rt,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_shamt,
    input  logic [15:0] i_imm,
    input  logic [25:0] i_target,
    output logic [31:0] o_word,
    output logic        o_valid_code
);

    always_comb begin
        o_word       = 32'h0000_0000;
        o_valid_code = 1'b1;
        case (i_code)
            CODE_ADDU: o_word = {OP_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FN_ADDU};
            CODE_SUBU: o_word = {OP_SPECIAL, i_rs, i_rt, i_rd, 5'd0, FN_SUBU};
            CODE_JR:   o_word = {OP_SPECIAL, i_rs, 15'd0, FN_JR};
            CODE_SLL:  o_word = {OP_SPECIAL, 5'd0, i_rt, i_rd, i_shamt, FN_SLL};
            CODE_ORI:  o_word = {OP_ORI, i_rs, i_rt, i_imm};
            CODE_LW:   o_word = {OP_LW, i_rs, i_rt, i_imm};
            CODE_SW:   o_word = {OP_SW, i_rs, i_rt, i_imm};
            CODE_BEQ:  o_word = {OP_BEQ, i_rs, i_rt, i_imm};
            CODE_LUI:  o_word = {OP_LUI, 5'd0, i_rt, i_imm};
            CODE_JAL:  o_word = {OP_JAL, i_target};
            default:   o_valid_code = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : instr_stream_encoder
// Description : Accepts one instruction per valid/ready handshake, encodes it
//               into a MIPS word and writes it to instruction memory at
//               consecutive word addresses starting at BASE_ADDR.
//               Optional feature macro: ENC_DELAY_SLOT_PAD_EN - after beq, jr
//               or jal a NOP is written automatically into the delay slot.
// Ports       : clk, reset            clock, synchronous active-high reset
//               start                 restart: pointer to 0, err cleared
//               in_valid / in_ready   request handshake
//               in_code, in_rs .. in_target   instruction code and fields
//               im_we/im_addr/im_wdata  registered IM write port
//               count                 words written since reset/start
//               full                  count == DEPTH
//               err                   sticky unsupported-code flag
// Revision    : 1.0 - initial release
// ============================================================================
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          DEPTH     = 1024,
    parameter int          CNT_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_code,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_ONE   = CNT_W'(1);
`ifdef ENC_DELAY_SLOT_PAD_EN
    // Any accepted request may need a following pad word, so keep two slots free
    localparam logic [CNT_W-1:0] c_PAD_LIMIT = CNT_W'(DEPTH - 2);
`endif

    enc_state_e       r_state;
    enc_state_e       w_state_nxt;
    logic             r_we;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [CNT_W-1:0] r_count;
    logic             r_err;

    logic [31:0]      w_word;
    logic             w_valid_code;
    logic             w_room;
    logic             w_ready;
    logic             w_accept;
    logic [31:0]      w_addr_cur;

    instr_field_packer u_packer (
        .i_code       (in_code),
        .i_rs         (in_rs),
        .i_rt         (in_rt),
        .i_rd         (in_rd),
        .i_shamt      (in_shamt),
        .i_imm        (in_imm),
        .i_target     (in_target),
        .o_word       (w_word),
        .o_valid_code (w_valid_code)
    );

`ifdef ENC_DELAY_SLOT_PAD_EN
    assign w_room = (r_count <= c_PAD_LIMIT);
`else
    assign w_room = (r_count < c_DEPTH);
`endif

    // Ready deliberately ignores in_valid and the fields
    assign w_ready    = !reset && !start && (r_state == ST_NORMAL) && w_room;
    assign w_accept   = in_valid && w_ready;
    assign w_addr_cur = BASE_ADDR + (32'(r_count) << 2);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_NORMAL: begin
`ifdef ENC_DELAY_SLOT_PAD_EN
                if (w_accept && w_valid_code && is_delay_slot_code(in_code)) begin
                    w_state_nxt = ST_PAD;
                end
`else
                w_state_nxt = ST_NORMAL;
`endif
            end
            ST_PAD:  w_state_nxt = ST_NORMAL;
            default: w_state_nxt = ST_NORMAL;
        endcase
        // A restart abandons any pending pad word
        if (start) begin
            w_state_nxt = ST_NORMAL;
        end
    end

    // ------------------------------------------------------------------
    // Write port, pointer and error flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_we    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_wdata <= 32'h0000_0000;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (start) begin
                r_addr  <= BASE_ADDR;
                r_count <= '0;
                r_err   <= 1'b0;
            end else if (r_state == ST_PAD) begin
                r_we    <= 1'b1;
                r_addr  <= w_addr_cur;
                r_wdata <= 32'h0000_0000;
                r_count <= r_count + c_ONE;
            end else if (w_accept) begin
                if (w_valid_code) begin
                    r_we    <= 1'b1;
                    r_addr  <= w_addr_cur;
                    r_wdata <= w_word;
                    r_count <= r_count + c_ONE;
                end else begin
                    // Unsupported code is consumed without a write
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign in_ready = w_ready;
    assign im_we    = r_we;
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign count    = r_count;
    assign full     = (r_count == c_DEPTH);
    assign err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_stream_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_stream_encoder
// Description : Self-checking bench for instr_stream_encoder. A table of
//               instructions with hand-encoded words, corner sequences
//               (unsupported code, start, reset in pad cycle, full) and
//               random traffic checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_stream_encoder;
    import instr_stream_encoder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0000_3000;
    localparam int          DEPTH = 1024;
`ifdef ENC_DELAY_SLOT_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready;
    logic [5:0]  in_code;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        im_we, full, err;
    logic [31:0] im_addr, im_wdata;
    logic [10:0] count;

    // Second instance with a tiny capacity for the full test
    logic        d4_reset, d4_start, d4_valid, d4_ready, d4_we, d4_full, d4_err;
    logic [5:0]  d4_code;
    logic [4:0]  d4_rs, d4_rt, d4_rd, d4_shamt;
    logic [15:0] d4_imm;
    logic [25:0] d4_target;
    logic [31:0] d4_addr, d4_wdata;
    logic [2:0]  d4_count;

    always #5 clk = ~clk;

    instr_stream_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .CNT_W(11)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_code(in_code), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_imm(in_imm), .in_target(in_target), .im_we(im_we), .im_addr(im_addr),
        .im_wdata(im_wdata), .count(count), .full(full), .err(err)
    );

    instr_stream_encoder #(.BASE_ADDR(BASE), .DEPTH(4), .CNT_W(3)) dut4 (
        .clk(clk), .reset(d4_reset), .start(d4_start), .in_valid(d4_valid), .in_ready(d4_ready),
        .in_code(d4_code), .in_rs(d4_rs), .in_rt(d4_rt), .in_rd(d4_rd), .in_shamt(d4_shamt),
        .in_imm(d4_imm), .in_target(d4_target), .im_we(d4_we), .im_addr(d4_addr),
        .im_wdata(d4_wdata), .count(d4_count), .full(d4_full), .err(d4_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model state
    logic        m_we, m_err, m_pad;
    logic [31:0] m_addr, m_wdata;
    int          m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Encoding rules written as field shifts from the instruction table
    function automatic logic [32:0] encode(input logic [5:0] code, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [4:0] sh, input logic [15:0] imm,
                                           input logic [25:0] tg);
        logic [31:0] w;
        logic        ok;
        ok = 1'b1;
        w  = 32'h0;
        case (code)
            CODE_ADDU: w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'h21;
            CODE_SUBU: w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'h23;
            CODE_JR:   w = (32'(rs) << 21) | 32'h08;
            CODE_SLL:  w = (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6);
            CODE_ORI:  w = (32'h0D << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            CODE_LW:   w = (32'h23 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            CODE_SW:   w = (32'h2B << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            CODE_BEQ:  w = (32'h04 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
            CODE_LUI:  w = (32'h0F << 26) | (32'(rt) << 16) | 32'(imm);
            CODE_JAL:  w = (32'h03 << 26) | 32'(tg);
            default:   ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    // One clock cycle: entered at a negedge with inputs already driven.
    // Checks outputs and ready, then advances the model across the posedge.
    task automatic step(input logic [31:0] ew, input logic ev, output logic acc);
        bit   room;
        logic rdy;
        bit   pad_code;
        #1;
        chk("im_we",    32'(im_we),    32'(m_we));
        chk("im_addr",  im_addr,       m_addr);
        chk("im_wdata", im_wdata,      m_wdata);
        chk("count",    32'(count),    32'(m_count));
        chk("err",      32'(err),      32'(m_err));
        chk("full",     32'(full),     32'(m_count == DEPTH));
        room = PAD_EN ? (m_count <= DEPTH - 2) : (m_count < DEPTH);
        rdy  = !reset && !start && !m_pad && room;
        chk("in_ready", 32'(in_ready), 32'(rdy));
        acc = in_valid && rdy;
        pad_code = (in_code == CODE_BEQ) || (in_code == CODE_JR) || (in_code == CODE_JAL);
        @(posedge clk);
        if (reset) begin
            m_we = 0; m_addr = BASE; m_wdata = 0; m_count = 0; m_err = 0; m_pad = 0;
        end else begin
            m_we = 0;
            if (start) begin
                m_addr = BASE; m_count = 0; m_err = 0; m_pad = 0;
            end else if (m_pad) begin
                m_we = 1; m_addr = BASE + 32'(4 * m_count); m_wdata = 0;
                m_count++; m_pad = 0;
            end else if (acc) begin
                if (ev) begin
                    m_we = 1; m_addr = BASE + 32'(4 * m_count); m_wdata = ew;
                    m_count++;
                    m_pad = PAD_EN && pad_code;
                end else begin
                    m_err = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        logic acc;
        in_valid = 0;
        step(32'h0, 1'b0, acc);
    endtask

    // Present one request and hold it until the model says it is taken
    task automatic send(input logic [5:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                        input logic [25:0] tg, input logic [31:0] ew, input logic ev);
        logic acc;
        acc = 0;
        in_valid = 1; in_code = c; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tg;
        for (int k = 0; k < 8 && !acc; k++) step(ew, ev, acc);
        if (!acc) chk("send_timeout", 32'(acc), 32'h1);
        in_valid = 0;
    endtask

    typedef struct {
        logic [5:0]  code;
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [25:0] tg;
        logic [31:0] word;
        logic        ok;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [32:0] e;
        int nw;

        vecs[0]  = '{CODE_ADDU, 5'd1,  5'd2, 5'd3,  5'd0, 16'h0000, 26'h0,      32'h0022_1821, 1'b1};
        vecs[1]  = '{CODE_ORI,  5'd0,  5'd1, 5'd0,  5'd0, 16'h1234, 26'h0,      32'h3401_1234, 1'b1};
        vecs[2]  = '{CODE_SLL,  5'd9,  5'd2, 5'd3,  5'd4, 16'h0000, 26'h0,      32'h0002_1900, 1'b1};
        vecs[3]  = '{CODE_LUI,  5'd7,  5'd1, 5'd0,  5'd0, 16'hFFFF, 26'h0,      32'h3C01_FFFF, 1'b1};
        vecs[4]  = '{CODE_SUBU, 5'd4,  5'd5, 5'd6,  5'd7, 16'hAAAA, 26'h0,      32'h0085_3023, 1'b1};
        vecs[5]  = '{CODE_JR,   5'd31, 5'd5, 5'd6,  5'd3, 16'h5555, 26'h3FF,    32'h03E0_0008, 1'b1};
        vecs[6]  = '{CODE_LW,   5'd29, 5'd8, 5'd1,  5'd1, 16'h0010, 26'h0,      32'h8FA8_0010, 1'b1};
        vecs[7]  = '{CODE_SW,   5'd0,  5'd2, 5'd0,  5'd0, 16'h0004, 26'h0,      32'hAC02_0004, 1'b1};
        vecs[8]  = '{CODE_BEQ,  5'd1,  5'd2, 5'd0,  5'd0, 16'hFFFF, 26'h0,      32'h1022_FFFF, 1'b1};
        vecs[9]  = '{CODE_JAL,  5'd3,  5'd4, 5'd5,  5'd6, 16'h1111, 26'h000C00, 32'h0C00_0C00, 1'b1};
        vecs[10] = '{6'h3F,     5'd1,  5'd2, 5'd3,  5'd4, 16'h1234, 26'h0,      32'h0000_0000, 1'b0};

        reset = 1; start = 0; in_valid = 0; in_code = 0; in_rs = 0; in_rt = 0; in_rd = 0;
        in_shamt = 0; in_imm = 0; in_target = 0;
        d4_reset = 1; d4_start = 0; d4_valid = 0; d4_code = 0; d4_rs = 0; d4_rt = 0;
        d4_rd = 0; d4_shamt = 0; d4_imm = 0; d4_target = 0;
        repeat (2) @(negedge clk);
        m_we = 0; m_addr = BASE; m_wdata = 0; m_count = 0; m_err = 0; m_pad = 0;

        // Reset state (in_ready must be low while reset is high)
        step(32'h0, 1'b0, acc);
        reset = 0;

        // Table: back-to-back requests with hand-encoded words
        for (int i = 0; i < 11; i++) begin
            send(vecs[i].code, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh,
                 vecs[i].imm, vecs[i].tg, vecs[i].word, vecs[i].ok);
        end
        idle();
        idle();
        chk("err_sticky", 32'(err), 32'h1);

        // start together with a valid request: start wins, request not taken
        start = 1; in_valid = 1; in_code = CODE_ADDU;
        step(32'h0022_1821, 1'b1, acc);
        start = 0; in_valid = 0;
        chk("start_clears_err", 32'(err), 32'h0);
        chk("start_clears_count", 32'(count), 32'h0);
        send(CODE_ADDU, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h0022_1821, 1'b1);
        chk("restart_addr", im_addr, BASE);
        chk("restart_we", 32'(im_we), 32'h1);
        idle();

        // Reset asserted in the cycle after a branch (the pad cycle when enabled)
        send(CODE_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b1);
        reset = 1;
        step(32'h0, 1'b0, acc);
        reset = 0;
        idle();
        chk("pad_reset_we", 32'(im_we), 32'h0);
        chk("pad_reset_count", 32'(count), 32'h0);

        // Branch followed by idle: pad word (if enabled) lands after it
        send(CODE_BEQ, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0, 32'h1022_FFFF, 1'b1);
        idle();
        idle();
        chk("branch_count", 32'(count), PAD_EN ? 32'd2 : 32'd1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            int r;
            reset    = ($urandom_range(0, 99) == 0);
            start    = ($urandom_range(0, 39) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 11);
            in_code  = (r < 10) ? 6'(r + 1) : 6'($urandom_range(0, 63));
            in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
            in_shamt = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
            e = encode(in_code, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
            step(e[31:0], e[32], acc);
        end
        reset = 0; start = 0; in_valid = 0;
        idle();

        // Capacity: DEPTH=4 instance, six sw requests offered continuously
        d4_reset = 0;
        d4_code = CODE_SW; d4_rs = 5'd0; d4_rt = 5'd2; d4_imm = 16'h0004;
        d4_valid = 1;
        nw = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (d4_we) begin
                chk("d4_addr", d4_addr, BASE + 32'(4 * nw));
                chk("d4_wdata", d4_wdata, 32'hAC02_0004);
                nw++;
            end
        end
        chk("d4_writes", 32'(nw), PAD_EN ? 32'd3 : 32'd4);
        chk("d4_count", 32'(d4_count), PAD_EN ? 32'd3 : 32'd4);
        chk("d4_full", 32'(d4_full), PAD_EN ? 32'd0 : 32'd1);
        chk("d4_ready", 32'(d4_ready), 32'h0);
        chk("d4_err", 32'(d4_err), 32'h0);
        d4_valid = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
